// File: rtl/arith_operand_sequencer.sv
// arith_operand_sequencer: push-button driven operand entry for the 8-bit
// add/subtract datapath. One switch bank is shared by both operands; each
// debounced press captures the next field. operands = {B, A}; the datapath
// consumes operands and sub combinationally.
//
// Optional build macro: ARITH_SEQ_CHAIN_EN
//   Adds result_in / btn_chain so that, from SHOW, the current sum can be
//   loaded back into A and a new B entered (chained operations).
//
// state   | meaning
// --------+-------------------------------------------------------------
// LOAD_A  | 2'b00 waiting for enter press to capture A from sw_in
// LOAD_B  | 2'b01 waiting for enter press to capture B and sub
// SHOW    | 2'b10 operation committed, valid high
// (2'b11) | illegal, recovers to LOAD_A on the next edge

// Synchronizer + debouncer + rising-edge pulse for one raw button.
module arith_seq_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   logic             sync1;
   logic             sync2;
   logic             lvl;
   logic             lvl_prev;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (sync2 == lvl) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         lvl <= ~lvl;
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Edge-detect history resets high so a rising edge is only recognised
   // once the debounced level has been observed low after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_prev <= 1'b1;
      end else begin
         lvl_prev <= lvl;
      end
   end

   assign press = lvl & ~lvl_prev;

endmodule

module arith_operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sw_in,
   input  logic        sub_in,
   input  logic        btn_enter,
`ifdef ARITH_SEQ_CHAIN_EN
   input  logic [7:0]  result_in,
   input  logic        btn_chain,
`endif
   output logic [15:0] operands,
   output logic        sub,
   output logic        valid,
   output logic [1:0]  phase
);

   localparam logic [1:0] LOAD_A = 2'b00;
   localparam logic [1:0] LOAD_B = 2'b01;
   localparam logic [1:0] SHOW   = 2'b10;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       press_enter;
   logic       press_chain;
   logic       sub_sync1;
   logic       sub_sync2;
   logic       cap_a;
   logic       cap_b;
   logic       cap_chain;

   arith_seq_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_enter (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_enter),
      .press   (press_enter)
   );

`ifdef ARITH_SEQ_CHAIN_EN
   arith_seq_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_chain (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_chain),
      .press   (press_chain)
   );
`else
   assign press_chain = 1'b0;
`endif

   // Operation switch is a raw board input; synchronize before capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_sync1 <= 1'b0;
         sub_sync2 <= 1'b0;
      end else begin
         sub_sync1 <= sub_in;
         sub_sync2 <= sub_sync1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD_A;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; enter has priority over chain in SHOW.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD_A: if (press_enter) state_nxt = LOAD_B;
         LOAD_B: if (press_enter) state_nxt = SHOW;
         SHOW: begin
            if (press_enter)      state_nxt = LOAD_A;
            else if (press_chain) state_nxt = LOAD_B;
         end
         default: state_nxt = LOAD_A;
      endcase
   end

   // Output decode: capture strobes, valid and status phase.
   always_comb begin
      cap_a     = (state == LOAD_A) && press_enter;
      cap_b     = (state == LOAD_B) && press_enter;
      cap_chain = (state == SHOW) && press_chain && !press_enter;
      valid     = (state == SHOW);
      phase     = state;
   end

   // Operand/sub registers change only on capture edges so the downstream
   // combinational result stays glitch-free between captures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operands <= 16'h0000;
         sub      <= 1'b0;
      end else begin
         if (cap_a) begin
            operands[7:0] <= sw_in;
         end
`ifdef ARITH_SEQ_CHAIN_EN
         if (cap_chain) begin
            operands[7:0] <= result_in;
         end
`endif
         if (cap_b) begin
            operands[15:8] <= sw_in;
            sub            <= sub_sync2;
         end
      end
   end

`ifndef ARITH_SEQ_CHAIN_EN
   logic unused_chain;
   assign unused_chain = cap_chain;
`endif

endmodule

// File: tb/tb_arith_operand_sequencer.sv
// Directed bench for arith_operand_sequencer with DEBOUNCE_CYCLES = 4.
// Chain scenarios are compiled in when ARITH_SEQ_CHAIN_EN is defined.
module tb_arith_operand_sequencer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  sw_in;
   logic        sub_in;
   logic        btn_enter;
`ifdef ARITH_SEQ_CHAIN_EN
   logic [7:0]  result_in;
   logic        btn_chain;
`endif
   logic [15:0] operands;
   logic        sub;
   logic        valid;
   logic [1:0]  phase;

   int checks;
   int errors;
   int changes;
   logic [1:0] last_phase;

   arith_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_in     (sw_in),
      .sub_in    (sub_in),
      .btn_enter (btn_enter),
`ifdef ARITH_SEQ_CHAIN_EN
      .result_in (result_in),
      .btn_chain (btn_chain),
`endif
      .operands  (operands),
      .sub       (sub),
      .valid     (valid),
      .phase     (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  sw;
      logic        sb;
      logic [15:0] exp_ops;
      logic        exp_sub;
      logic        exp_valid;
      logic [1:0]  exp_phase;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic b);
      btn_enter = b;
      tick();
      if (phase !== last_phase) changes++;
      last_phase = phase;
   endtask

   task automatic press_clean();
      repeat (10) step(1'b1);
      repeat (12) step(1'b0);
   endtask

   // Edges from raw rising edge to phase change; 99 marks a timeout.
   task automatic measure(output int lat);
      logic [1:0] start;
      start = phase;
      lat = 99;
      btn_enter = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (phase !== start && lat == 99) lat = i;
      end
      btn_enter = 1'b0;
      repeat (12) tick();
      last_phase = phase;
   endtask

`ifdef ARITH_SEQ_CHAIN_EN
   task automatic step2(input logic be, input logic bc);
      btn_enter = be;
      btn_chain = bc;
      tick();
      last_phase = phase;
   endtask
`endif

   initial begin
      int lat;
      checks = 0;
      errors = 0;
      changes = 0;

      vecs[0] = '{8'h05, 1'b1, 16'h0005, 1'b0, 1'b0, 2'b01};
      vecs[1] = '{8'h03, 1'b1, 16'h0305, 1'b1, 1'b1, 2'b10};
      vecs[2] = '{8'hAA, 1'b0, 16'h0305, 1'b1, 1'b0, 2'b00};
      vecs[3] = '{8'hFF, 1'b0, 16'h03FF, 1'b1, 1'b0, 2'b01};
      vecs[4] = '{8'h80, 1'b0, 16'h80FF, 1'b0, 1'b1, 2'b10};
      vecs[5] = '{8'h11, 1'b1, 16'h80FF, 1'b0, 1'b0, 2'b00};

      rst_n = 1'b0;
      sw_in = 8'h00;
      sub_in = 1'b0;
      btn_enter = 1'b0;
`ifdef ARITH_SEQ_CHAIN_EN
      result_in = 8'h00;
      btn_chain = 1'b0;
`endif
      repeat (3) tick();
      check("rst_operands", operands, 16'h0000);
      check("rst_sub", {15'd0, sub}, 16'd0);
      check("rst_valid", {15'd0, valid}, 16'd0);
      check("rst_phase", {14'd0, phase}, 16'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      last_phase = phase;

      // Full sequence with latency measurement.
      sw_in = 8'h05;
      measure(lat);
      check("lat_a", 16'(lat), 16'd7);
      check("seq_a_phase", {14'd0, phase}, 16'h0001);
      check("seq_a_ops", operands, 16'h0005);
      sw_in = 8'h03;
      sub_in = 1'b1;
      measure(lat);
      check("lat_b", 16'(lat), 16'd7);
      check("seq_ops", operands, 16'h0305);
      check("seq_sub", {15'd0, sub}, 16'd1);
      check("seq_valid", {15'd0, valid}, 16'd1);
      check("seq_phase", {14'd0, phase}, 16'h0002);

      // Asynchronous reset mid-SHOW, away from any clock edge.
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_operands", operands, 16'h0000);
      check("arst_sub", {15'd0, sub}, 16'd0);
      check("arst_valid", {15'd0, valid}, 16'd0);
      check("arst_phase", {14'd0, phase}, 16'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      last_phase = phase;

      // Table-driven press sequence.
      for (int i = 0; i < 6; i++) begin
         sw_in = vecs[i].sw;
         sub_in = vecs[i].sb;
         press_clean();
         check($sformatf("vec%0d_ops", i), operands, vecs[i].exp_ops);
         check($sformatf("vec%0d_sub", i), {15'd0, sub}, {15'd0, vecs[i].exp_sub});
         check($sformatf("vec%0d_valid", i), {15'd0, valid}, {15'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_phase", i), {14'd0, phase}, {14'd0, vecs[i].exp_phase});
      end

      // Bounce then steady hold: exactly one capture.
      sw_in = 8'h22;
      changes = 0;
      last_phase = phase;
      step(1'b1); step(1'b0); step(1'b1); step(1'b0);
      repeat (20) step(1'b1);
      repeat (12) step(1'b0);
      check("bounce_changes", 16'(changes), 16'd1);
      check("bounce_phase", {14'd0, phase}, 16'h0001);
      check("bounce_ops", operands, 16'h8022);

      // 3-cycle pulse is shorter than the debounce window.
      sw_in = 8'h33;
      changes = 0;
      repeat (3) step(1'b1);
      repeat (12) step(1'b0);
      check("short_changes", 16'(changes), 16'd0);
      check("short_phase", {14'd0, phase}, 16'h0001);
      check("short_ops", operands, 16'h8022);

      // Long hold: one advance, nothing on release.
      sw_in = 8'h44;
      sub_in = 1'b0;
      changes = 0;
      repeat (100) step(1'b1);
      repeat (20) step(1'b0);
      check("hold_changes", 16'(changes), 16'd1);
      check("hold_phase", {14'd0, phase}, 16'h0002);
      check("hold_ops", operands, 16'h4422);
      check("hold_valid", {15'd0, valid}, 16'd1);

      // Wrap from SHOW keeps operands.
      sw_in = 8'h99;
      press_clean();
      check("wrap_phase", {14'd0, phase}, 16'h0000);
      check("wrap_valid", {15'd0, valid}, 16'd0);
      check("wrap_ops", operands, 16'h4422);

`ifdef ARITH_SEQ_CHAIN_EN
      sw_in = 8'h07;
      press_clean();
      sw_in = 8'h01;
      press_clean();
      check("chain_pre_ops", operands, 16'h0107);
      check("chain_pre_phase", {14'd0, phase}, 16'h0002);
      result_in = 8'h02;
      repeat (10) step2(1'b0, 1'b1);
      repeat (12) step2(1'b0, 1'b0);
      check("chain_ops_lo", {8'd0, operands[7:0]}, 16'h0002);
      check("chain_phase", {14'd0, phase}, 16'h0001);
      check("chain_valid", {15'd0, valid}, 16'd0);
      sw_in = 8'h09;
      press_clean();
      check("chain_show_ops", operands, 16'h0902);
      repeat (10) step2(1'b1, 1'b1);
      repeat (12) step2(1'b0, 1'b0);
      check("chain_both_phase", {14'd0, phase}, 16'h0000);
      check("chain_both_ops", operands, 16'h0902);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
